// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU memory-side blocks:
//   - arb_state_e : memory arbiter FSM states (IDLE, BUSY, ACK)
//   - PORT_I/D    : owner encodings for the fetch and load/store requesters
//   - cnt_width() : width of a down-counter that must hold (latency - 1)
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  // Owner encoding; also the bit index of each port in a 2-bit req/grant vector.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // A latency of 1 still needs a 1-bit counter so the FSM has no zero-width vector.
  function automatic int cnt_width(input int latency);
    if (latency > 2) begin
      return $clog2(latency);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]   in  request vector, bit PORT_I = fetch, bit PORT_D = data
//   last       in  owner of the previous grant
//   grant[1:0] out one-hot grant (all zero when nothing is requested)
// On a tie the requester that did not win last time is granted.
// -----------------------------------------------------------------------------
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Grant selection: single requester wins outright, a tie goes to !last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (last == PORT_D) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single word-addressed memory port between instruction fetch
// (port I, read-only) and load/store (port D, read/write). Holds the memory
// strobes for LATENCY cycles, then pulses the owner's ack for one cycle and
// spends that cycle as bus turnaround before accepting a new request.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                fetch request and address
//   i_ack/i_rdata               fetch completion pulse and read data (held)
//   d_req/d_we/d_addr/d_wdata   load/store request, direction, address, data
//   d_ack/d_rdata               load/store completion pulse and load data (held)
//   mem_re/mem_we               memory read/write strobes (never together)
//   memaddr/mem_wdata           memory address and write data (held)
//   mem_rdata                   memory read data, valid in the last strobe cycle
//   busy                        high whenever the FSM is not IDLE
// LATENCY must be at least 1.
// -----------------------------------------------------------------------------
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] memaddr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_owner;
  logic          r_write;
  logic          r_mem_re;
  logic          r_mem_we;
  logic          r_i_ack;
  logic          r_d_ack;
  logic          r_busy;
  logic [AW-1:0] r_memaddr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;

  logic [1:0]    w_req;
  logic [1:0]    w_grant;
  logic          w_grant_any;
  logic          w_grant_d;
  logic          w_grant_we;
  logic [AW-1:0] w_grant_addr;

  assign w_req = {d_req, i_req};

  rr_arb2 u_rr_arb2 (
    .req   (w_req),
    .last  (r_last),
    .grant (w_grant)
  );

  // Decode of the winner: a fetch always reads, only a D grant can write.
  assign w_grant_any  = |w_grant;
  assign w_grant_d    = w_grant[1];
  assign w_grant_we   = w_grant_d & d_we;
  assign w_grant_addr = w_grant_d ? d_addr : i_addr;

  // Arbiter FSM with latency counter and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= CNT_ZERO;
      r_last      <= PORT_D;
      r_owner     <= PORT_I;
      r_write     <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_busy      <= 1'b0;
      r_memaddr   <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_i_rdata   <= {DW{1'b0}};
      r_d_rdata   <= {DW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_owner   <= w_grant_d ? PORT_D : PORT_I;
            r_last    <= w_grant_d ? PORT_D : PORT_I;
            r_write   <= w_grant_we;
            r_memaddr <= w_grant_addr;
            if (w_grant_d) begin
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_wdata <= r_mem_wdata;
            end
            r_mem_re  <= ~w_grant_we;
            r_mem_we  <= w_grant_we;
            r_cnt     <= CNT_LOAD;
            r_busy    <= 1'b1;
            r_state   <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          // Counter only steps down from nonzero, so it can never wrap.
          if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            if (!r_write) begin
              if (r_owner == PORT_D) begin
                r_d_rdata <= mem_rdata;
              end else begin
                r_i_rdata <= mem_rdata;
              end
            end else begin
              r_d_rdata <= r_d_rdata;
            end
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_owner == PORT_D) begin
              r_d_ack <= 1'b1;
            end else begin
              r_i_ack <= 1'b1;
            end
            r_state <= ACK;
          end
        end
        ACK: begin
          // Requests are deliberately not sampled here: one turnaround cycle.
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          r_i_ack  <= 1'b0;
          r_d_ack  <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= CNT_ZERO;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign memaddr   = r_memaddr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
